// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: FSM state encoding,
// data/byte-enable widths and the word-address width helper.
package dmem_pkg;

    localparam int DATA_W = 32;
    localparam int BE_W   = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } stateT;

    // Number of word-index bits for a power-of-two depth (at least one bit).
    function automatic int wordAddrBits(input int depthWords);
        return (depthWords > 1) ? $clog2(depthWords) : 1;
    endfunction

endpackage

// File: rtl/dmem_ram_bank.sv
// Word-organised 32-bit RAM with per-byte write enables and a registered
// (synchronous) read port. One access per cycle: either a write or a read.
// INIT_ZERO states that storage is expected to start at zero in simulation;
// the array itself is never reset.
module dmem_ram_bank
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 512,
    parameter int INIT_ZERO   = 1,
    parameter int ADDR_W      = wordAddrBits(DEPTH_WORDS)
) (
    input  logic              CLOCK,
    input  logic              writeEn,
    input  logic              readEn,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [BE_W-1:0]   be,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH_WORDS];

    // Without zero fill the contents simply start undefined; no logic differs.
    if (INIT_ZERO == 0) begin : gNoZeroFill
    end

    // Byte-masked write and registered read on the same port.
    // NOTE: the storage array has no reset branch on purpose: a reset loop over
    // every word cannot map onto RAM macros, and the contents must survive reset.
    always_ff @(posedge CLOCK) begin
        if (writeEn) begin
            for (int b = 0; b < BE_W; b++) begin
                if (be[b]) begin
                    mem[addr][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
        if (readEn) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder for the CPU MEM stage: valid/ready request and
// response channels, one outstanding transaction, WAIT_CYCLES wait states.
// A request accepted at edge t is answered with rsp_valid high after edge
// t+1+WAIT_CYCLES; the RAM access happens on the edge that enters RESP.
// Optional feature macro: DMEM_RANGE_ERR_EN (out-of-range or misaligned
// addresses answer with rsp_err=1 and never touch the RAM).
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 512,
    parameter int WAIT_CYCLES = 2,
    parameter int INIT_ZERO   = 1
) (
    input  logic              CLOCK,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [DATA_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [BE_W-1:0]   req_be,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              busy
);

    localparam int ADDR_W = wordAddrBits(DEPTH_WORDS);

    stateT             state;
    logic [3:0]        waitCnt;
    logic              latWe;
    logic [ADDR_W-1:0] latIdx;
    logic [DATA_W-1:0] latWdata;
    logic [BE_W-1:0]   latBe;
    logic              latErr;
    logic              rspValidQ;
    logic              reqErr;
    logic              accessNow;
    logic [DATA_W-1:0] ramRdata;

`ifdef DMEM_RANGE_ERR_EN
    localparam logic [DATA_W:0] ADDR_LIMIT = (DATA_W + 1)'(DEPTH_WORDS) << 2;

    assign reqErr  = ({1'b0, req_addr} >= ADDR_LIMIT) || (req_addr[1:0] != 2'b00);
    assign rsp_err = (state == RESP) && latErr;
`else
    // Upper and byte-offset address bits are deliberately ignored (wrap).
    logic unusedAddrBits;
    assign unusedAddrBits = ^{req_addr[DATA_W-1:ADDR_W+2], req_addr[1:0]};
    assign reqErr  = 1'b0;
    assign rsp_err = 1'b0;
`endif

    assign req_ready = (state == IDLE) && rst;
    assign busy      = (state != IDLE);
    assign rsp_valid = rspValidQ;

    // The RAM is touched exactly once, on the last WAIT edge (the one entering RESP).
    assign accessNow = (state == WAIT) && (waitCnt == 4'd0) && !latErr;

    // The RAM read register only updates on a load access, so it holds steady in RESP.
    assign rsp_rdata = ((state == RESP) && !latWe && !latErr) ? ramRdata : '0;

    dmem_ram_bank #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .INIT_ZERO   (INIT_ZERO),
        .ADDR_W      (ADDR_W)
    ) ramBank (
        .CLOCK   (CLOCK),
        .writeEn (accessNow && latWe),
        .readEn  (accessNow && !latWe),
        .addr    (latIdx),
        .wdata   (latWdata),
        .be      (latBe),
        .rdata   (ramRdata)
    );

    // Request/response FSM: latch on accept, count wait states, hold the response.
    // NOTE: state registers use non-blocking assignments so every register
    // samples pre-edge values and simulation order cannot change the result.
    always_ff @(posedge CLOCK or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            waitCnt   <= 4'd0;
            latWe     <= 1'b0;
            latIdx    <= '0;
            latWdata  <= '0;
            latBe     <= '0;
            latErr    <= 1'b0;
            rspValidQ <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        latWe    <= req_we;
                        latIdx   <= req_addr[ADDR_W+1:2];
                        latWdata <= req_wdata;
                        latBe    <= req_be;
                        latErr   <= reqErr;
                        waitCnt  <= 4'(WAIT_CYCLES);
                        state    <= WAIT;
                    end
                end
                WAIT: begin
                    if (waitCnt == 4'd0) begin
                        state     <= RESP;
                        rspValidQ <= 1'b1;
                    end else begin
                        waitCnt <= waitCnt - 4'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state     <= IDLE;
                        rspValidQ <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    rspValidQ <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: instance 0 uses WAIT_CYCLES=2, instance 1
// uses WAIT_CYCLES=0; both DEPTH_WORDS=512. Expected values are hand-derived.
module tb_dmem_responder;

`ifdef DMEM_RANGE_ERR_EN
    localparam bit RANGE_ERR = 1'b1;
`else
    localparam bit RANGE_ERR = 1'b0;
`endif
    localparam int LAT_LIMIT = 40;

    logic        CLOCK;
    logic        rst;
    logic        reqValid  [2];
    logic        reqReady  [2];
    logic        reqWe     [2];
    logic [31:0] reqAddr   [2];
    logic [31:0] reqWdata  [2];
    logic [3:0]  reqBe     [2];
    logic        rspValid  [2];
    logic        rspReady  [2];
    logic [31:0] rspRdata  [2];
    logic        rspErr    [2];
    logic        busy      [2];

    int checks   = 0;
    int failures = 0;

    dmem_responder #(.DEPTH_WORDS(512), .WAIT_CYCLES(2), .INIT_ZERO(1)) dutW2 (
        .CLOCK(CLOCK), .rst(rst),
        .req_valid(reqValid[0]), .req_ready(reqReady[0]), .req_we(reqWe[0]),
        .req_addr(reqAddr[0]), .req_wdata(reqWdata[0]), .req_be(reqBe[0]),
        .rsp_valid(rspValid[0]), .rsp_ready(rspReady[0]), .rsp_rdata(rspRdata[0]),
        .rsp_err(rspErr[0]), .busy(busy[0])
    );

    dmem_responder #(.DEPTH_WORDS(512), .WAIT_CYCLES(0), .INIT_ZERO(1)) dutW0 (
        .CLOCK(CLOCK), .rst(rst),
        .req_valid(reqValid[1]), .req_ready(reqReady[1]), .req_we(reqWe[1]),
        .req_addr(reqAddr[1]), .req_wdata(reqWdata[1]), .req_be(reqBe[1]),
        .rsp_valid(rspValid[1]), .rsp_ready(rspReady[1]), .rsp_rdata(rspRdata[1]),
        .rsp_err(rspErr[1]), .busy(busy[1])
    );

    initial begin
        CLOCK = 1'b0;
        forever #5 CLOCK = ~CLOCK;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%08h expected=%08h", tag, got, exp);
        end
    endtask

    // One complete transaction with rsp_ready high; reports latency in edges
    // counted from the accepting edge.
    task automatic xfer(input int d, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] be,
                        output logic [31:0] rdata, output logic err, output int lat);
        @(negedge CLOCK);
        reqValid[d] = 1'b1;
        reqWe[d]    = we;
        reqAddr[d]  = addr;
        reqWdata[d] = wdata;
        reqBe[d]    = be;
        @(posedge CLOCK);
        @(negedge CLOCK);
        reqValid[d] = 1'b0;
        reqWe[d]    = 1'b0;
        lat = 0;
        while (rspValid[d] !== 1'b1 && lat < LAT_LIMIT) begin
            @(posedge CLOCK);
            lat++;
            @(negedge CLOCK);
        end
        rdata = rspRdata[d];
        err   = rspErr[d];
        @(posedge CLOCK);
    endtask

    task automatic txn(input string tag, input int d, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] be,
                       input int expLat, input logic [31:0] expData, input logic expErr);
        logic [31:0] rd;
        logic        er;
        int          lat;
        xfer(d, we, addr, wdata, be, rd, er, lat);
        check({tag, "_lat"}, 32'(lat), 32'(expLat));
        check({tag, "_data"}, rd, expData);
        check({tag, "_err"}, {31'd0, er}, {31'd0, expErr});
    endtask

    initial begin
        int waited;
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            reqValid[i] = 1'b0;
            reqWe[i]    = 1'b0;
            reqAddr[i]  = '0;
            reqWdata[i] = '0;
            reqBe[i]    = '0;
            rspReady[i] = 1'b1;
        end

        // Reset state
        #12;
        check("rst_rsp_valid", {31'd0, rspValid[0]}, 32'd0);
        check("rst_req_ready", {31'd0, reqReady[0]}, 32'd0);
        check("rst_busy",      {31'd0, busy[0]}, 32'd0);
        check("rst_rdata",     rspRdata[0], 32'h0);
        check("rst_err",       {31'd0, rspErr[0]}, 32'd0);
        @(negedge CLOCK);
        rst = 1'b1;
        @(negedge CLOCK);
        check("post_rst_ready", {31'd0, reqReady[0]}, 32'd1);

        // Known contents for the words later read back
        txn("init10", 0, 1'b1, 32'h10, 32'h0, 4'hF, 3, 32'h0, 1'b0);
        txn("init00", 1, 1'b1, 32'h0,  32'h0, 4'hF, 1, 32'h0, 1'b0);

        // Reset in the middle of WAIT drops the pending store
        @(negedge CLOCK);
        reqValid[0] = 1'b1; reqWe[0] = 1'b1; reqAddr[0] = 32'h10;
        reqWdata[0] = 32'hDEADBEEF; reqBe[0] = 4'hF;
        @(posedge CLOCK);
        @(negedge CLOCK);
        reqValid[0] = 1'b0; reqWe[0] = 1'b0;
        check("midwait_busy", {31'd0, busy[0]}, 32'd1);
        #2 rst = 1'b0;
        #1;
        check("abort_rsp_valid", {31'd0, rspValid[0]}, 32'd0);
        check("abort_busy",      {31'd0, busy[0]}, 32'd0);
        check("abort_req_ready", {31'd0, reqReady[0]}, 32'd0);
        repeat (3) @(negedge CLOCK);
        rst = 1'b1;
        #1;
        check("release_req_ready", {31'd0, reqReady[0]}, 32'd1);
        txn("abort_load10", 0, 1'b0, 32'h10, 32'h0, 4'h0, 3, 32'h0, 1'b0);

        // Latency with WAIT_CYCLES=2
        txn("lat_store20", 0, 1'b1, 32'h20, 32'h12345678, 4'hF, 3, 32'h0, 1'b0);
        txn("lat_load20",  0, 1'b0, 32'h20, 32'h0, 4'h0, 3, 32'h12345678, 1'b0);

        // Byte enables
        txn("be_full",  0, 1'b1, 32'h40, 32'hAABBCCDD, 4'b1111, 3, 32'h0, 1'b0);
        txn("be_0101",  0, 1'b1, 32'h40, 32'h11223344, 4'b0101, 3, 32'h0, 1'b0);
        txn("be_load",  0, 1'b0, 32'h40, 32'h0, 4'h0, 3, 32'hAA22CC44, 1'b0);
        txn("be_none",  0, 1'b1, 32'h40, 32'hFFFFFFFF, 4'b0000, 3, 32'h0, 1'b0);
        txn("be_load2", 0, 1'b0, 32'h40, 32'h0, 4'h0, 3, 32'hAA22CC44, 1'b0);

        // Response backpressure: rsp_ready low for 5 cycles during a load response
        rspReady[0] = 1'b0;
        @(negedge CLOCK);
        reqValid[0] = 1'b1; reqWe[0] = 1'b0; reqAddr[0] = 32'h40;
        @(posedge CLOCK);
        @(negedge CLOCK);
        reqValid[0] = 1'b0;
        waited = 0;
        while (rspValid[0] !== 1'b1 && waited < LAT_LIMIT) begin
            @(negedge CLOCK);
            waited++;
        end
        check("bp_first_valid", {31'd0, rspValid[0]}, 32'd1);
        for (int c = 0; c < 5; c++) begin
            @(posedge CLOCK);
            @(negedge CLOCK);
            check("bp_valid", {31'd0, rspValid[0]}, 32'd1);
            check("bp_rdata", rspRdata[0], 32'hAA22CC44);
            check("bp_busy",  {31'd0, busy[0]}, 32'd1);
            check("bp_ready", {31'd0, reqReady[0]}, 32'd0);
        end
        rspReady[0] = 1'b1;
        @(posedge CLOCK);
        @(negedge CLOCK);
        check("bp_after_valid", {31'd0, rspValid[0]}, 32'd0);
        check("bp_after_ready", {31'd0, reqReady[0]}, 32'd1);
        reqValid[0] = 1'b1; reqWe[0] = 1'b0; reqAddr[0] = 32'h20;
        @(posedge CLOCK);
        @(negedge CLOCK);
        reqValid[0] = 1'b0;
        check("bp_next_busy",  {31'd0, busy[0]}, 32'd1);
        check("bp_next_ready", {31'd0, reqReady[0]}, 32'd0);
        waited = 0;
        while (rspValid[0] !== 1'b1 && waited < LAT_LIMIT) begin
            @(negedge CLOCK);
            waited++;
        end
        check("bp_next_data", rspRdata[0], 32'h12345678);
        @(posedge CLOCK);

        // Zero wait states and address wrap / range error
        txn("w0_load00",    1, 1'b0, 32'h000, 32'h0, 4'h0, 1, 32'h0, 1'b0);
        txn("w0_store800",  1, 1'b1, 32'h800, 32'hCAFEF00D, 4'hF, 1, 32'h0, RANGE_ERR);
        txn("w0_reload00",  1, 1'b0, 32'h000, 32'h0, 4'h0, 1,
            RANGE_ERR ? 32'h0 : 32'hCAFEF00D, 1'b0);

        // Misaligned access
        txn("mis_load42", 0, 1'b0, 32'h42, 32'h0, 4'h0, 3,
            RANGE_ERR ? 32'h0 : 32'hAA22CC44, RANGE_ERR);
        txn("mis_load40", 0, 1'b0, 32'h40, 32'h0, 4'h0, 3, 32'hAA22CC44, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
